// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control sequencer.
// Holds opcode values, ALUOp / ALUSrcB / PCSource encodings and the 4-bit state enum.
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  // ALUOp encodings
  localparam logic [2:0] AluOpAnd   = 3'b000;
  localparam logic [2:0] AluOpOr    = 3'b001;
  localparam logic [2:0] AluOpAdd   = 3'b010;
  localparam logic [2:0] AluOpSub   = 3'b011;
  localparam logic [2:0] AluOpFunct = 3'b100;

  // ALUSrcB encodings
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StIExec   = 4'd10,
    StIWb     = 4'd11
  } state_e;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OpAddi) || (op == OpAndi) || (op == OpOri);
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
           (op == OpJ) || is_imm_op(op);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder: maps the current sequencer state (plus mem_ready,
// zero and, in DECODE / I_EXEC, the opcode) onto the datapath control outputs.
// Ports: state/opcode/zero/mem_ready in, force_off in (holds every output at 0),
// ALU/mux selects, enables, pc_en, instr_done and illegal out.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       force_off,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal
);

  logic pc_write;
  logic pc_write_cond;

  always_comb begin
    ALUOp         = AluOpAnd;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SrcBReg;
    ZeroExt       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    PCSource      = PcSrcAlu;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    if (!force_off) begin
      case (state)
        StFetch: begin
          MemRead  = 1'b1;
          ALUSrcB  = SrcBFour;
          ALUOp    = AluOpAdd;
          // IR and PC update exactly once, on the cycle the fetch completes
          IRWrite  = mem_ready;
          pc_write = mem_ready;
        end
        StDecode: begin
          ALUSrcB = SrcBImmSh2;
          ALUOp   = AluOpAdd;
          illegal = !is_known_op(opcode);
        end
        StMemAddr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SrcBImm;
          ALUOp   = AluOpAdd;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        StMemWr: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        StRExec: begin
          ALUSrcA = 1'b1;
          ALUOp   = AluOpFunct;
        end
        StRWb: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        StBranch: begin
          ALUSrcA       = 1'b1;
          ALUOp         = AluOpSub;
          PCSource      = PcSrcAluOut;
          pc_write_cond = 1'b1;
          instr_done    = 1'b1;
        end
        StJump: begin
          pc_write   = 1'b1;
          PCSource   = PcSrcJump;
          instr_done = 1'b1;
        end
        StIExec: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SrcBImm;
          if (opcode == OpAndi) begin
            ALUOp   = AluOpAnd;
            ZeroExt = 1'b1;
          end else if (opcode == OpOri) begin
            ALUOp   = AluOpOr;
            ZeroExt = 1'b1;
          end else begin
            ALUOp = AluOpAdd;
          end
        end
        StIWb: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control sequencer for the multicycle MIPS datapath.
// Holds the state register and next-state logic; control outputs come from mips_ctrl_outdec.
// Ports: clk, rst (async, active-high), opcode, zero, mem_ready in; ALUOp, mux selects,
// memory/IR/register enables, pc_en, instr_done, illegal and debug state out.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  // lw/sw choice is captured in DECODE so MEM_ADDR does not depend on the opcode input
  logic   is_store_q, is_store_d;

  always_comb begin
    state_d    = StFetch;
    is_store_d = is_store_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
        else           state_d = StFetch;
      end
      StDecode: begin
        is_store_d = (opcode == OpSw);
        if ((opcode == OpLw) || (opcode == OpSw)) state_d = StMemAddr;
        else if (opcode == OpRtype)               state_d = StRExec;
        else if (opcode == OpBeq)                 state_d = StBranch;
        else if (opcode == OpJ)                   state_d = StJump;
        else if (is_imm_op(opcode))               state_d = StIExec;
        else                                      state_d = StFetch;
      end
      StMemAddr: begin
        if (is_store_q) state_d = StMemWr;
        else            state_d = StMemRd;
      end
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
        else           state_d = StMemRd;
      end
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
        else           state_d = StMemWr;
      end
      StRExec: state_d = StRWb;
      StIExec: state_d = StIWb;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  assign state = state_q;

  mips_ctrl_outdec u_outdec (
    .state      (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .force_off  (rst),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ZeroExt    (ZeroExt),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .PCSource   (PCSource),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed instruction sequences with literal expectations,
// then randomized opcodes/mem_ready/zero/reset checked every cycle against a behavioural model
// that walks each instruction along its list of steps.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
  logic [1:0] PCSource;
  logic       pc_en, instr_done, illegal;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ZeroExt    (ZeroExt),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .PCSource   (PCSource),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       zext, iord, mrd, mwr, irw, rw, rdst, m2r;
    logic [1:0] pcs;
    logic       pcen, done, ill;
    logic [3:0] st;
  } ctl_t;

  ctl_t dut_c;
  ctl_t lg [16];
  int   n_pass = 0;
  int   n_total = 0;

  logic [5:0] legal_ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b001000, 6'b001100, 6'b001101};

  always_comb begin
    dut_c.aluop = ALUOp;
    dut_c.srca  = ALUSrcA;
    dut_c.srcb  = ALUSrcB;
    dut_c.zext  = ZeroExt;
    dut_c.iord  = IorD;
    dut_c.mrd   = MemRead;
    dut_c.mwr   = MemWrite;
    dut_c.irw   = IRWrite;
    dut_c.rw    = RegWrite;
    dut_c.rdst  = RegDst;
    dut_c.m2r   = MemtoReg;
    dut_c.pcs   = PCSource;
    dut_c.pcen  = pc_en;
    dut_c.done  = instr_done;
    dut_c.ill   = illegal;
    dut_c.st    = state;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t: got %h, want %h", name, $time, got, want);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected control word for a given step, straight from the per-state output table
  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic z,
                                   input logic rdy, input logic r);
    ctl_t c;
    c = '0;
    if (r) return c;
    c.st = 4'(st);
    case (st)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.aluop = 3'b010; c.irw = rdy; c.pcen = rdy; end
      1:  begin c.srcb = 2'b11; c.aluop = 3'b010; c.ill = !is_legal(op); end
      2:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 3'b010; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; c.done = 1; end
      5:  begin c.mwr = 1; c.iord = 1; c.done = rdy; end
      6:  begin c.srca = 1; c.aluop = 3'b100; end
      7:  begin c.rw = 1; c.rdst = 1; c.done = 1; end
      8:  begin c.srca = 1; c.aluop = 3'b011; c.pcs = 2'b01; c.pcen = z; c.done = 1; end
      9:  begin c.pcen = 1; c.pcs = 2'b10; c.done = 1; end
      10: begin
        c.srca = 1;
        c.srcb = 2'b10;
        if (op == 6'b001100)      begin c.aluop = 3'b000; c.zext = 1; end
        else if (op == 6'b001101) begin c.aluop = 3'b001; c.zext = 1; end
        else                            c.aluop = 3'b010;
      end
      11: begin c.rw = 1; c.done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Behavioural model: each instruction is FETCH, DECODE, then a list of steps chosen in
  // DECODE; FETCH, MEM_RD and MEM_WR repeat while mem_ready is low.
  int m_st = 0;
  int route[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0;
      route.delete();
    end else if ((m_st == 0 || m_st == 3 || m_st == 5) && !mem_ready) begin
      m_st = m_st;
    end else if (m_st == 0) begin
      m_st = 1;
    end else begin
      if (m_st == 1) begin
        if (opcode == 6'b100011)      route = '{2, 3, 4};
        else if (opcode == 6'b101011) route = '{2, 5};
        else if (opcode == 6'b000000) route = '{6, 7};
        else if (opcode == 6'b000100) route = '{8};
        else if (opcode == 6'b000010) route = '{9};
        else if (opcode == 6'b001000 || opcode == 6'b001100 || opcode == 6'b001101)
          route = '{10, 11};
        else route.delete();
      end
      if (route.size() > 0) m_st = route.pop_front();
      else                  m_st = 0;
    end
  end

  always @(negedge clk) begin : cmp
    ctl_t e;
    e = exp_ctl(m_st, opcode, zero, mem_ready, rst);
    chk($sformatf("cycle_model st=%0d", m_st), 32'(dut_c), 32'(e));
  end

  // One instruction (or part of one); seq holds expected state per cycle, nibble 0 first
  task automatic run_seq(input string name, input logic [5:0] op, input logic z, input int n,
                         input logic [63:0] seq, input logic [15:0] rdy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      opcode    = op;
      zero      = z;
      mem_ready = rdy[i];
      @(negedge clk);
      lg[i] = dut_c;
      chk($sformatf("%s_state%0d", name, i), 32'(state), 32'(seq[4*i +: 4]));
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outputs", 32'(dut_c), 32'd0);
    rst = 1'b0;

    run_seq("rtype", 6'b000000, 1'b0, 4, 64'h7610, 16'hF);
    chk("rtype_aluop_exec", 32'(lg[2].aluop), 32'h4);
    chk("rtype_rw_exec", 32'(lg[2].rw), 32'h0);
    chk("rtype_rw_rdst_wb", 32'({lg[3].rw, lg[3].rdst}), 32'h3);
    chk("rtype_done", 32'({lg[3].done, lg[2].done, lg[1].done, lg[0].done}), 32'h8);

    run_seq("lw", 6'b100011, 1'b0, 7, 64'h4333210, 16'h0067);
    chk("lw_mrd_iord", 32'({lg[3].mrd, lg[3].iord, lg[4].mrd, lg[4].iord,
                            lg[5].mrd, lg[5].iord}), 32'h3F);
    chk("lw_wb", 32'({lg[6].rw, lg[6].m2r, lg[5].rw, lg[5].m2r}), 32'hC);

    run_seq("beq_taken", 6'b000100, 1'b1, 3, 64'h810, 16'h7);
    chk("beq_taken_pc", 32'({lg[2].pcen, lg[2].pcs, lg[2].aluop}), 32'({1'b1, 2'b01, 3'b011}));
    run_seq("beq_not", 6'b000100, 1'b0, 3, 64'h810, 16'h7);
    chk("beq_not_pc", 32'({lg[2].pcen, lg[2].aluop}), 32'({1'b0, 3'b011}));

    run_seq("ori", 6'b001101, 1'b0, 4, 64'hBA10, 16'hF);
    chk("ori_exec", 32'({lg[2].aluop, lg[2].zext}), 32'({3'b001, 1'b1}));
    chk("ori_wb", 32'({lg[3].rw, lg[3].rdst}), 32'h2);
    run_seq("addi", 6'b001000, 1'b0, 4, 64'hBA10, 16'hF);
    chk("addi_exec", 32'({lg[2].aluop, lg[2].zext}), 32'({3'b010, 1'b0}));

    run_seq("illegal", 6'b111111, 1'b0, 3, 64'h010, 16'h3);
    chk("illegal_pulse", 32'({lg[2].ill, lg[1].ill, lg[0].ill}), 32'h2);
    chk("illegal_no_write", 32'({lg[0].rw, lg[0].mwr, lg[1].rw, lg[1].mwr,
                                 lg[2].rw, lg[2].mwr}), 32'h0);

    run_seq("sw_stall", 6'b101011, 1'b0, 5, 64'h55210, 16'h7);
    chk("sw_mwr_held", 32'({lg[3].mwr, lg[4].mwr, lg[4].done}), 32'h6);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'(dut_c), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    run_seq("post_rst", 6'b000000, 1'b0, 4, 64'h7610, 16'hF);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom_range(0, 1));
      if (m_st == 0) begin
        if ($urandom_range(0, 7) != 0) opcode = legal_ops[$urandom_range(0, 7)];
        else                           opcode = 6'($urandom);
      end else if ((m_st >= 2 && m_st <= 9) || m_st == 11) begin
        // opcode is only meaningful in DECODE and I_EXEC
        opcode = 6'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
